// File: rtl/tmr_vote_pkg.sv
// tmr_vote_pkg: shared constants, FSM states and helper functions for the TMR voter.
package tmr_vote_pkg;
    localparam int NCH = 3;
    typedef enum logic {COLLECT, OUTPUT} state_t;
    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction
    // lowest equal pair: 0=(0,1) 1=(0,2) 2=(1,2) 3=no pair agrees
    function automatic logic [1:0] pair_eq(input logic eq01, input logic eq02, input logic eq12);
        return eq01 ? 2'd0 : eq02 ? 2'd1 : eq12 ? 2'd2 : 2'd3;
    endfunction
endpackage

// File: rtl/tmr_vote_ctrl_if.sv
// tmr_vote_ctrl_if: three producer handshakes plus the voted-result handshake.
interface tmr_vote_ctrl_if #(parameter int WIDTH = 8);
    logic [2:0]         ch_valid;
    logic [3*WIDTH-1:0] ch_data;
    logic [2:0]         ch_ready;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [2:0]         out_mismatch;
    logic               out_degraded;
    logic               out_fail;
    modport master(output ch_valid, ch_data, out_ready,
                   input ch_ready, out_valid, out_data, out_mismatch, out_degraded, out_fail);
    modport slave(input ch_valid, ch_data, out_ready,
                  output ch_ready, out_valid, out_data, out_mismatch, out_degraded, out_fail);
endinterface

// File: rtl/tmr_vote_ctrl_maj3.sv
// maj3_vec: combinational bitwise 2-of-3 majority.
module maj3_vec #(parameter int WIDTH = 8) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    output logic [WIDTH-1:0] o_y
);
    assign o_y = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

// File: rtl/tmr_vote_ctrl.sv
// tmr_vote_ctrl: collects three redundant words, votes them and tracks faulty channels.
// Optional TMR_VOTE_STATS_EN adds saturating per-channel mismatch totals on mis_cnt.
module tmr_vote_ctrl
    import tmr_vote_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int TIMEOUT      = 16,
    parameter int FAULT_THRESH = 3
`ifdef TMR_VOTE_STATS_EN
    , parameter int CNT_W      = 8
`endif
) (
    input  logic           CP,
    input  logic           CD,
    tmr_vote_ctrl_if.slave bus,
    input  logic           clr_fault,
    output logic [2:0]     fault
`ifdef TMR_VOTE_STATS_EN
    , output logic [3*CNT_W-1:0] mis_cnt
`endif
);
    localparam int TW = $clog2(TIMEOUT + 2);
    localparam int CW = $clog2(FAULT_THRESH + 1);

    state_t           r_state, w_state_nx;
    logic [2:0]       r_cap, w_cap, w_take, w_mis;
    logic [WIDTH-1:0] r_d [NCH];
    logic [WIDTH-1:0] w_d [NCH];
    logic [TW-1:0]    r_timer;
    logic [1:0]       w_n;
    logic             w_go, w_acc, w_fail, w_deg;
    logic [WIDTH-1:0] w_maj, w_low, w_vote;
    logic             r_out_valid, r_out_deg, r_out_fail;
    logic [WIDTH-1:0] r_out_data;
    logic [2:0]       r_out_mis, r_fault;
    logic [CW-1:0]    r_cc [NCH];

    // ready is gated by CD so every output reads 0 while reset is held
    assign bus.ch_ready = (CD && r_state == COLLECT) ? ~r_cap : 3'b000;
    assign w_take       = bus.ch_valid & bus.ch_ready;
    assign w_cap        = r_cap | w_take;
    assign w_n          = popcount3(w_cap);
    assign w_go         = r_state == COLLECT && (w_n == 2'd3 || (r_timer == TW'(TIMEOUT) && w_cap != 3'b000));
    assign w_acc        = r_state == OUTPUT && bus.out_ready;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign w_d[i]   = w_take[i] ? bus.ch_data[i*WIDTH +: WIDTH] : r_d[i];
        assign w_mis[i] = ~w_cap[i] | (w_d[i] != w_vote);
    end

    maj3_vec #(.WIDTH(WIDTH)) u_maj (.i_a(w_d[0]), .i_b(w_d[1]), .i_c(w_d[2]), .o_y(w_maj));

    // partial votes report the lowest captured word whether or not a pair agrees
    assign w_low  = w_cap[0] ? w_d[0] : w_cap[1] ? w_d[1] : w_d[2];
    assign w_vote = w_n == 2'd3 ? w_maj : w_low;
    assign w_deg  = w_n != 2'd3;
    assign w_fail = pair_eq(w_cap[0] & w_cap[1] & (w_d[0] == w_d[1]),
                            w_cap[0] & w_cap[2] & (w_d[0] == w_d[2]),
                            w_cap[1] & w_cap[2] & (w_d[1] == w_d[2])) == 2'd3;

    always_ff @(posedge CP or negedge CD)
        if (!CD) r_state <= COLLECT;
        else     r_state <= w_state_nx;

    always_comb w_state_nx = w_go ? OUTPUT : w_acc ? COLLECT : r_state;

    always_ff @(posedge CP or negedge CD) begin
        if (!CD) begin
            r_cap   <= 3'b000;
            r_timer <= '0;
            r_d     <= '{default: '0};
        end else if (w_acc) begin
            r_cap   <= 3'b000;
            r_timer <= '0;
        end else if (r_state == COLLECT) begin
            r_cap   <= w_cap;
            r_d     <= w_d;
            if (w_cap != 3'b000) r_timer <= r_timer + 1'b1;
        end
    end

    always_ff @(posedge CP or negedge CD) begin
        if (!CD) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_mis   <= 3'b000;
            r_out_deg   <= 1'b0;
            r_out_fail  <= 1'b0;
        end else if (w_go) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_vote;
            r_out_mis   <= w_mis;
            r_out_deg   <= w_deg;
            r_out_fail  <= w_fail;
        end else if (w_acc) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_valid    = r_out_valid;
    assign bus.out_data     = r_out_data;
    assign bus.out_mismatch = r_out_mis;
    assign bus.out_degraded = r_out_deg;
    assign bus.out_fail     = r_out_fail;

    always_ff @(posedge CP or negedge CD) begin
        if (!CD) begin
            r_cc    <= '{default: '0};
            r_fault <= 3'b000;
        end else if (clr_fault) begin
            r_cc    <= '{default: '0};
            r_fault <= 3'b000;
        end else if (w_acc) begin
            for (int i = 0; i < NCH; i++) begin
                r_cc[i] <= !r_out_mis[i] ? '0 : (r_cc[i] == CW'(FAULT_THRESH)) ? r_cc[i] : r_cc[i] + 1'b1;
                if (r_out_mis[i] && r_cc[i] >= CW'(FAULT_THRESH - 1)) r_fault[i] <= 1'b1;
            end
        end
    end

    assign fault = r_fault;

`ifdef TMR_VOTE_STATS_EN
    logic [CNT_W-1:0] r_cnt [NCH];

    always_ff @(posedge CP or negedge CD) begin
        if (!CD) begin
            r_cnt <= '{default: '0};
        end else if (w_acc) begin
            for (int i = 0; i < NCH; i++)
                if (r_out_mis[i] && r_cnt[i] != '1) r_cnt[i] <= r_cnt[i] + 1'b1;
        end
    end

    assign mis_cnt = {r_cnt[2], r_cnt[1], r_cnt[0]};
`endif
endmodule

// File: tb/tb_tmr_vote_ctrl.sv
// tb_tmr_vote_ctrl: directed and randomized transactions checked against a transaction-level voter model.
module tb_tmr_vote_ctrl;
    localparam int W  = 8;
    localparam int TO = 6;
    localparam int TH = 3;

    logic       CP = 1'b0;
    logic       CD = 1'b0;
    logic       clr_fault = 1'b0;
    logic [2:0] fault;
`ifdef TMR_VOTE_STATS_EN
    logic [23:0] mis_cnt;
`endif

    tmr_vote_ctrl_if #(.WIDTH(W)) bus();

    tmr_vote_ctrl #(.WIDTH(W), .TIMEOUT(TO), .FAULT_THRESH(TH)) dut (
        .CP(CP), .CD(CD), .bus(bus), .clr_fault(clr_fault), .fault(fault)
`ifdef TMR_VOTE_STATS_EN
        , .mis_cnt(mis_cnt)
`endif
    );

    always #5 CP = ~CP;

    int         checks = 0;
    int         failures = 0;
    int         m_cc [3];
    int         m_cnt [3];
    logic [2:0] m_fault;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cc[i]  = 0;
            m_cnt[i] = 0;
        end
        m_fault = 3'b000;
    endtask

    // arr[i]: cycle offset at which channel i raises valid (-1 = never)
    task automatic txn(input int arr[3], input logic [7:0] d[3], input int hold, input logic clr, input string tag);
        int         f, last, v, n;
        bit         all3;
        bit         cap [3];
        logic [7:0] vote;
        logic [2:0] mis, rdy;
        logic       fail, deg;
        logic [31:0] expv;
        f = 1000; last = -1; all3 = 1; n = 0;
        for (int i = 0; i < 3; i++)
            if (arr[i] >= 0) begin
                if (arr[i] < f) f = arr[i];
                if (arr[i] > last) last = arr[i];
            end else all3 = 0;
        v = (all3 && last <= f + TO) ? last : f + TO;
        for (int i = 0; i < 3; i++) begin
            cap[i] = arr[i] >= 0 && arr[i] <= v;
            n += int'(cap[i]);
        end
        vote = 8'h00;
        if (n == 3) begin
            for (int b = 0; b < 8; b++)
                vote[b] = (int'(d[0][b]) + int'(d[1][b]) + int'(d[2][b])) >= 2;
        end else begin
            for (int i = 2; i >= 0; i--) if (cap[i]) vote = d[i];
        end
        fail = 1'b1;
        for (int i = 0; i < 3; i++)
            for (int j = i + 1; j < 3; j++)
                if (cap[i] && cap[j] && d[i] == d[j]) fail = 1'b0;
        for (int i = 0; i < 3; i++) mis[i] = !cap[i] || d[i] != vote;
        deg = n < 3;
        bus.ch_data = {d[2], d[1], d[0]};
        for (int c = 0; c <= v; c++) begin
            @(negedge CP);
            for (int i = 0; i < 3; i++) rdy[i] = !(arr[i] >= 0 && arr[i] < c);
            check({tag, "_collect"}, 32'({bus.out_valid, bus.ch_ready}), 32'({1'b0, rdy}));
            for (int i = 0; i < 3; i++) bus.ch_valid[i] = arr[i] >= 0 && c >= arr[i];
        end
        @(negedge CP);
        bus.ch_valid = 3'b000;
        expv = 32'({1'b1, 3'b000, vote, mis, deg, fail});
        check({tag, "_vote"}, 32'({bus.out_valid, bus.ch_ready, bus.out_data, bus.out_mismatch, bus.out_degraded, bus.out_fail}), expv);
        for (int h = 0; h < hold; h++) begin
            @(negedge CP);
            check({tag, "_hold"}, 32'({bus.out_valid, bus.ch_ready, bus.out_data, bus.out_mismatch, bus.out_degraded, bus.out_fail}), expv);
        end
        bus.out_ready = 1'b1;
        clr_fault = clr;
        @(negedge CP);
        bus.out_ready = 1'b0;
        clr_fault = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_cc[i] = clr ? 0 : !mis[i] ? 0 : (m_cc[i] + 1 > TH ? TH : m_cc[i] + 1);
            if (m_cc[i] == TH) m_fault[i] = 1'b1;
            if (mis[i] && m_cnt[i] < 255) m_cnt[i]++;
        end
        if (clr) m_fault = 3'b000;
        check({tag, "_accept"}, 32'({bus.out_valid, bus.ch_ready, fault}), 32'({1'b0, 3'b111, m_fault}));
`ifdef TMR_VOTE_STATS_EN
        check({tag, "_stats"}, 32'(mis_cnt), 32'({8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])}));
`endif
    endtask

    initial begin
        bus.ch_valid = 3'b000;
        bus.ch_data = '0;
        bus.out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge CP);
        check("reset", 32'({bus.out_valid, bus.ch_ready, bus.out_data, bus.out_mismatch, bus.out_degraded, bus.out_fail, fault}), 32'd0);
        CD = 1'b1;

        txn('{0, 0, 0}, '{8'hA5, 8'hA5, 8'hA5}, 0, 1'b0, "t1_all_equal");
        txn('{0, 0, 0}, '{8'hA5, 8'hA5, 8'h5A}, 4, 1'b0, "t2_backpressure");
        txn('{0, 0, -1}, '{8'h3C, 8'h3C, 8'h00}, 0, 1'b0, "t3_timeout");
        for (int k = 0; k < 3; k++)
            txn('{0, 0, 0}, '{8'h01, 8'h02, 8'h04}, 1, 1'b0, "t4_no_majority");
        check("t4_fault_set", 32'(fault), 32'(3'b111));
        clr_fault = 1'b1;
        @(negedge CP);
        clr_fault = 1'b0;
        for (int i = 0; i < 3; i++) m_cc[i] = 0;
        m_fault = 3'b000;
        check("t4_fault_clr", 32'(fault), 32'(3'b000));

        @(negedge CP);
        bus.ch_data = {8'h00, 8'h11, 8'h11};
        bus.ch_valid = 3'b011;
        @(negedge CP);
        bus.ch_valid = 3'b000;
        #2 CD = 1'b0;
        #1;
        model_reset();
`ifdef TMR_VOTE_STATS_EN
        check("t6_reset_stats", 32'(mis_cnt), 32'd0);
`endif
        check("t6_async_reset", 32'({bus.out_valid, bus.ch_ready, bus.out_data, bus.out_mismatch, bus.out_degraded, bus.out_fail, fault}), 32'd0);
        @(negedge CP);
        CD = 1'b1;
        txn('{2, 2, 0}, '{8'h77, 8'h77, 8'h77}, 0, 1'b0, "t6_after_reset");

        txn('{0, 0, 0}, '{8'h42, 8'h99, 8'h42}, 0, 1'b0, "t5_mis");
        txn('{0, 0, 0}, '{8'h42, 8'h99, 8'h42}, 0, 1'b0, "t5_mis");
        txn('{0, 0, 0}, '{8'h42, 8'h42, 8'h42}, 0, 1'b0, "t5_match");
        txn('{0, 0, 0}, '{8'h42, 8'h99, 8'h42}, 0, 1'b0, "t5_mis");
        txn('{0, 0, 0}, '{8'h42, 8'h99, 8'h42}, 0, 1'b0, "t5_mis");
        check("t5_fault1", 32'(fault[1]), 32'd0);
`ifdef TMR_VOTE_STATS_EN
        check("t5_stats1", 32'(mis_cnt[15:8]), 32'd4);
`endif

        for (int t = 0; t < 40; t++) begin
            int         arr [3];
            logic [7:0] d [3];
            logic [7:0] base;
            base = 8'($urandom);
            for (int i = 0; i < 3; i++) begin
                arr[i] = ($urandom_range(0, 6) == 0) ? -1 : int'($urandom_range(0, TO + 3));
                d[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : base;
            end
            if (arr[0] < 0 && arr[1] < 0 && arr[2] < 0) arr[0] = 0;
            txn(arr, d, int'($urandom_range(0, 3)), $urandom_range(0, 9) == 0, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
